lock_code_entry: RTL and testbench

LOCK_CODE_ENTRY -- requirements
Module: lock_code_entry

---
 rtl/lock_pkg.sv | 30 +++
 rtl/btn_edge.sv | 29 ++
 rtl/lock_code_entry.sv | 172 +++++++++++++++++
 tb/tb_lock_code_entry.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared display codes, symbol codes and FSM state type for the lock
// Optional lockout feature: LOCK_CODE_ENTRY_LOCKOUT_EN
package lock_pkg;

    localparam logic [3:0] DIG_A     = 4'd0;
    localparam logic [3:0] DIG_B     = 4'd1;
    localparam logic [3:0] DIG_C     = 4'd2;
    localparam logic [3:0] DIG_L     = 4'd3;
    localparam logic [3:0] DIG_U     = 4'd4;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    localparam logic [1:0] SYM_A = 2'd0;
    localparam logic [1:0] SYM_B = 2'd1;
    localparam logic [1:0] SYM_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        UNLOCKED
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
        , LOCKOUT
`endif
    } state_e;

    // Symbol codes line up with the A/B/C display codes.
    function automatic logic [3:0] sym_digit(input logic [1:0] sym);
        return {2'b00, sym};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - per-bit rising-edge detector; reset preloads current levels
module btn_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    always_comb begin
        prev_d = level;
    end

    // Loading levels during reset keeps a button held across release from firing.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= level;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/lock_code_entry.sv
// rtl/lock_code_entry.sv - three-button combination lock with optional lockout
// Optional lockout feature: LOCK_CODE_ENTRY_LOCKOUT_EN
module lock_code_entry
    import lock_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter logic [13:0] COMBO          = 14'b00_10_01_00,
    parameter int          MAX_TRIES      = 3,
    parameter int          LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       btn_lock,
    output logic [3:0] digit,
    output logic       unlocked,
    output logic       locked_out,
    output logic [2:0] entry_count
);

    localparam int SW = 2 * CODE_LEN;

    logic [3:0] rise;
    logic       one_sym;
    logic [1:0] sym;
    logic       last_sym;
    logic [SW-1:0] syms_ins;

    state_e        state_q,       state_d;
    logic [3:0]    digit_q,       digit_d;
    logic          unlocked_q,    unlocked_d;
    logic [2:0]    entry_count_q, entry_count_d;
    logic [SW-1:0] syms_q,        syms_d;

    btn_edge #(.W(4)) u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .level ({btn_lock, btn_c, btn_b, btn_a}),
        .rise  (rise)
    );

    assign one_sym  = (rise[2:0] == 3'b001) || (rise[2:0] == 3'b010) || (rise[2:0] == 3'b100);
    assign sym      = rise[1] ? SYM_B : (rise[2] ? SYM_C : SYM_A);
    assign last_sym = (entry_count_q == 3'(CODE_LEN - 1));

    // Candidate symbol store with the current press dropped into its slot.
    always_comb begin
        syms_ins = (state_q == IDLE) ? '0 : syms_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (i == int'(entry_count_q)) begin
                syms_ins[2*i +: 2] = sym;
            end
        end
    end

`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
    logic        locked_out_q, locked_out_d;
    logic [2:0]  fail_q,       fail_d;
    logic [19:0] lock_cnt_q,   lock_cnt_d;
    logic [2:0]  fail_inc;

    assign fail_inc   = (fail_q == 3'(MAX_TRIES)) ? fail_q : fail_q + 3'd1;
    assign locked_out = locked_out_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{MAX_TRIES[2:0], LOCKOUT_CYCLES[0]};
    assign locked_out = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        digit_d       = digit_q;
        unlocked_d    = unlocked_q;
        entry_count_d = entry_count_q;
        syms_d        = syms_q;
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
        locked_out_d  = locked_out_q;
        fail_d        = fail_q;
        lock_cnt_d    = lock_cnt_q;
`endif
        case (state_q)
            IDLE, ENTRY: begin
                if (one_sym) begin
                    syms_d  = syms_ins;
                    digit_d = sym_digit(sym);
                    if (state_q == ENTRY && last_sym) begin
                        entry_count_d = 3'd0;
                        if (syms_ins == COMBO[SW-1:0]) begin
                            state_d    = UNLOCKED;
                            digit_d    = DIG_U;
                            unlocked_d = 1'b1;
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
                            fail_d     = 3'd0;
`endif
                        end else begin
                            state_d = IDLE;
                            digit_d = DIG_L;
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
                            fail_d  = fail_inc;
                            if (fail_inc == 3'(MAX_TRIES)) begin
                                state_d      = LOCKOUT;
                                digit_d      = DIG_BLANK;
                                locked_out_d = 1'b1;
                                lock_cnt_d   = 20'(LOCKOUT_CYCLES - 1);
                            end
`endif
                        end
                    end else begin
                        state_d       = ENTRY;
                        entry_count_d = entry_count_q + 3'd1;
                    end
                end
            end
            UNLOCKED: begin
                if (rise[3]) begin
                    state_d    = IDLE;
                    digit_d    = DIG_L;
                    unlocked_d = 1'b0;
                end
            end
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
            LOCKOUT: begin
                if (lock_cnt_q == 20'd0) begin
                    state_d      = IDLE;
                    digit_d      = DIG_L;
                    locked_out_d = 1'b0;
                    fail_d       = 3'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q - 20'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                digit_d = DIG_L;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            digit_q       <= DIG_L;
            unlocked_q    <= 1'b0;
            entry_count_q <= 3'd0;
            syms_q        <= '0;
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
            locked_out_q  <= 1'b0;
            fail_q        <= 3'd0;
            lock_cnt_q    <= 20'd0;
`endif
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            unlocked_q    <= unlocked_d;
            entry_count_q <= entry_count_d;
            syms_q        <= syms_d;
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
            locked_out_q  <= locked_out_d;
            fail_q        <= fail_d;
            lock_cnt_q    <= lock_cnt_d;
`endif
        end
    end

    assign digit       = digit_q;
    assign unlocked    = unlocked_q;
    assign entry_count = entry_count_q;

endmodule

// File: tb/tb_lock_code_entry.sv
// tb/tb_lock_code_entry.sv - randomized bench against an attempt-level lock model
module tb_lock_code_entry;

    localparam int          CODE_LEN       = 4;
    localparam logic [13:0] COMBO          = 14'b00_10_01_00;
    localparam int          MAX_TRIES      = 3;
    localparam int          LOCKOUT_CYCLES = 1000;
`ifdef LOCK_CODE_ENTRY_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0, btn_lock = 1'b0;
    logic [3:0] digit;
    logic       unlocked, locked_out;
    logic [2:0] entry_count;

    lock_code_entry #(
        .CODE_LEN       (CODE_LEN),
        .COMBO          (COMBO),
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_a       (btn_a),
        .btn_b       (btn_b),
        .btn_c       (btn_c),
        .btn_lock    (btn_lock),
        .digit       (digit),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .entry_count (entry_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 entering, 2 open, 3 locked out
    int         m_mode = 0;
    int         m_syms[$];
    int         m_tries = 0;
    int         m_left = 0;
    int         m_digit = 3;
    logic [3:0] m_prev = 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int combo_sym(input int i);
        logic [13:0] c;
        c = COMBO >> (2 * i);
        return int'(c[1:0]);
    endfunction

    task automatic model_update(input logic r, input logic [3:0] lv);
        logic [3:0] rise;
        int         n;
        int         s;
        bit         ok;
        if (r) begin
            m_prev = lv;
            m_mode = 0;
            m_syms.delete();
            m_tries = 0;
            m_left = 0;
            m_digit = 3;
            return;
        end
        rise = lv & ~m_prev;
        m_prev = lv;
        n = int'(rise[0]) + int'(rise[1]) + int'(rise[2]);
        s = rise[0] ? 0 : (rise[1] ? 1 : 2);
        case (m_mode)
            0, 1: begin
                if (n == 1) begin
                    m_syms.push_back(s);
                    m_digit = s;
                    m_mode = 1;
                    if (m_syms.size() == CODE_LEN) begin
                        ok = 1'b1;
                        for (int i = 0; i < CODE_LEN; i++)
                            if (m_syms[i] != combo_sym(i)) ok = 1'b0;
                        m_syms.delete();
                        if (ok) begin
                            m_mode = 2;
                            m_digit = 4;
                            m_tries = 0;
                        end else begin
                            if (m_tries < MAX_TRIES) m_tries++;
                            if (LOCK_EN && m_tries == MAX_TRIES) begin
                                m_mode = 3;
                                m_digit = 15;
                                m_left = LOCKOUT_CYCLES;
                            end else begin
                                m_mode = 0;
                                m_digit = 3;
                            end
                        end
                    end
                end
            end
            2: begin
                if (rise[3]) begin
                    m_mode = 0;
                    m_digit = 3;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0;
                    m_digit = 3;
                    m_tries = 0;
                end
            end
        endcase
    endtask

    // lv = {lock, c, b, a}
    task automatic step(input logic r, input logic [3:0] lv);
        @(negedge clk);
        rst = r;
        btn_a = lv[0];
        btn_b = lv[1];
        btn_c = lv[2];
        btn_lock = lv[3];
        @(posedge clk);
        model_update(r, lv);
        #1;
        check("digit", 32'(digit), 32'(m_digit));
        check("unlocked", 32'(unlocked), 32'(m_mode == 2));
        check("locked_out", 32'(locked_out), 32'(m_mode == 3));
        check("entry_count", 32'(entry_count), 32'(m_syms.size()));
    endtask

    task automatic press(input int s);
        step(1'b0, 4'(1 << s));
        step(1'b0, 4'd0);
    endtask

    int lk_cycles;
    logic [3:0] rlv;
    int r;

    initial begin
        step(1'b1, 4'd0);
        step(1'b1, 4'd0);
        check("rst_digit", 32'(digit), 32'd3);
        check("rst_entry_count", 32'(entry_count), 32'd0);
        check("rst_unlocked", 32'(unlocked), 32'd0);
        step(1'b0, 4'd0);

        // Correct combination A,B,C,A
        for (int i = 0; i < CODE_LEN; i++) begin
            step(1'b0, 4'(1 << combo_sym(i)));
            if (i < CODE_LEN - 1) check("combo_digit", 32'(digit), 32'(combo_sym(i)));
            step(1'b0, 4'd0);
        end
        check("open_digit", 32'(digit), 32'd4);
        check("open_unlocked", 32'(unlocked), 32'd1);

        // Symbol ignored while open, then relock
        step(1'b0, 4'b0100);
        check("open_ignore_c", 32'(digit), 32'd4);
        step(1'b0, 4'd0);
        step(1'b0, 4'b1000);
        check("relock_digit", 32'(digit), 32'd3);
        check("relock_unlocked", 32'(unlocked), 32'd0);
        step(1'b0, 4'd0);

        // Simultaneous A and B rises are discarded
        press(0);
        step(1'b0, 4'b0011);
        check("dual_entry_count", 32'(entry_count), 32'd1);
        check("dual_digit", 32'(digit), 32'd0);
        step(1'b0, 4'd0);

        // Three wrong attempts and lockout length
        step(1'b1, 4'd0);
        lk_cycles = 0;
        for (int k = 0; k < 3 * CODE_LEN; k++) begin
            step(1'b0, 4'b0001);
            if (locked_out) lk_cycles++;
            step(1'b0, 4'd0);
            if (locked_out) lk_cycles++;
        end
        for (int k = 0; k < LOCKOUT_CYCLES + 10; k++) begin
            step(1'b0, (k % 7 == 3) ? 4'b0001 : 4'd0);
            if (locked_out) lk_cycles++;
        end
        check("lockout_len", 32'(lk_cycles), LOCK_EN ? 32'(LOCKOUT_CYCLES) : 32'd0);
        check("post_lockout_digit", 32'(digit), 32'd3);

        // btn_b held through reset release
        step(1'b1, 4'd0);
        press(0);
        press(1);
        check("pre_rst_count", 32'(entry_count), 32'd2);
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0010);
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0010);
        check("held_count", 32'(entry_count), 32'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'b0010);
        check("repress_count", 32'(entry_count), 32'd1);
        check("repress_digit", 32'(digit), 32'd1);
        step(1'b0, 4'd0);

        // Random traffic with occasional correct combos and resets
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                step(1'b1, 4'($urandom_range(0, 15)));
            end else if (r < 6) begin
                for (int i = 0; i < CODE_LEN; i++) press(combo_sym(i));
            end else begin
                for (int b = 0; b < 4; b++) rlv[b] = ($urandom_range(0, 3) == 0);
                step(1'b0, rlv);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
